pipelined_decode_stage: RTL and testbench
=========================================

# pipelined_decode_stage

MIPS32 instruction-decode stage: field extraction, register-file read with write-back bypass, immediate extension, destination-register selection, and an ID/EX pipeline register. It sits between fetch and execute. It replaces the combinational decode stage with a registered, stallable and flushable stage. A single load-use interlock inserts bubbles, and a valid/ready handshake accepts back-pressure from execute.

## Interface
- AWIDTH, 5, register address width; register file has 2**AWIDTH entries. MIPS32 fields are 5 bits wide, so only 5 is legal.
- DWIDTH, 32, register and extended-immediate data width; must be ≥ IMM_WIDTH.
- IWIDTH, 32, instruction width.
- IMM_WIDTH, 16, raw immediate field width.
- pds_clk  in  1  clock; all state updates on the rising edge.
- pds_rst  in  1  asynchronous, active-low reset.
- pds_i_ce  in  1  fetch presents a valid instruction.
- pds_i_instr  in  IWIDTH  instruction word.
- pds_o_stall  out  1  combinational; fetch must hold pds_i_instr/pds_i_ce.
- pds_i_flush  in  1  kill the instruction presented this cycle.
- pds_i_ex_ready  in  1  execute accepts the current output this cycle.
- pds_i_ex_load  in  1  instruction currently in EX is a load.
- pds_i_ex_dest  in  AWIDTH  destination register of the EX instruction.
- pds_i_wb_en, pds_i_wb_addr[AWIDTH], pds_i_wb_data[DWIDTH]  in  write-back port.
- pds_o_ce  out  1  ID/EX valid.
- pds_o_opcode[6], pds_o_funct[6]  out  registered opcode and funct fields.
- pds_o_addr_rs, pds_o_addr_rt, pds_o_dest  out  AWIDTH  registered source and destination addresses.
- pds_o_data_rs, pds_o_data_rt  out  DWIDTH  registered operands.
- pds_o_imm  out  DWIDTH  registered extended immediate.
- pds_o_reg_wr  out  1  instruction writes a register.

## Operation
- Instruction fields:
  - opcode = instr[31:26]
  - rs = [25:21], rt = [20:16], rd = [15:11]
  - funct = [5:0], imm = [15:0]
- Register file:
  - 2**AWIDTH × DWIDTH; all entries cleared by reset.
  - Write on the rising edge when pds_i_wb_en=1 and wb_addr≠0.
  - Register 0 always reads 0.
- Read bypass: if pds_i_wb_en=1, wb_addr≠0 and wb_addr equals the read address, that read returns pds_i_wb_data in the same cycle.
- Destination select:
  - opcode 0x00 → rd
  - opcode 0x03 (jal) → 31
  - otherwise → rt
- reg_wr is 1 for:
  - R-type, except funct 0x08 (jr)
  - opcodes 0x08–0x0F (addi/addiu/slti/sltiu/andi/ori/xori/lui)
  - 0x23 (lw) and 0x03 (jal)
  - reg_wr is 0 for all other opcodes.
- Immediate extension: zero-extend for opcodes 0x0C/0x0D/0x0E; sign-extend for all others.
- rt is a read source for R-type, 0x04/0x05 (beq/bne) and 0x2B (sw).
- load_use is asserted when all of the following hold:
  - pds_i_ce=1
  - pds_i_ex_load=1
  - ex_dest≠0
  - ex_dest equals rs, or ex_dest equals rt and rt is a read source.
- hold = pds_o_ce & ~pds_i_ex_ready.
- pds_o_stall = ~pds_i_flush & (hold | load_use).
- ID/EX update priority on each rising edge:
  1. flush: pds_o_ce←0; other outputs are don't-care.
  2. hold: all outputs keep their values.
  3. load_use: pds_o_ce←0 (bubble); the instruction stays at the input.
  4. otherwise: load the decoded fields; pds_o_ce←pds_i_ce.
- An instruction is accepted when pds_i_ce=1 and pds_o_stall=0.

## Timing
- Reset (pds_rst=0, asynchronous): every output and every register-file entry is 0, including pds_o_ce=0. pds_o_stall is combinational and evaluates to 0 while reset is held.
- Latency: an instruction accepted at edge N appears on the outputs after edge N (1 cycle).
- Throughput: 1 instruction/cycle with no stall.
- A load-use hazard costs exactly 1 bubble cycle, then the instruction issues.
- Write-back and read of the same register in the same cycle return the new data (bypass). The register file is also updated at that edge.
- Flush and hold together: flush wins, and pds_o_stall=0.
- Reset asserted mid-stall clears the pipeline register immediately. The register file is also cleared.

## Test plan
- Reset, then one instruction:
  - Stimulus: hold pds_rst=0 while driving inputs; release, then present add $3,$1,$2 (0x00221820) with wb pre-loads $1=5, $2=7.
  - Response: all outputs stay 0 during reset; after one edge pds_o_ce=1, data_rs=5, data_rt=7, dest=3, reg_wr=1.
- Immediate extension:
  - addi imm 0xFFFF → pds_o_imm=0xFFFFFFFF.
  - ori imm 0xFFFF → 0x0000FFFF.
  - lui → reg_wr=1, dest=rt.
- Write-back bypass and register 0:
  - Same-cycle write $4=0xA5A5A5A5 while reading $4 → data_rs=0xA5A5A5A5 on the next edge.
  - Write to $0, then read $0 → 0.
- Load-use interlock:
  - Stimulus: ex_load=1, ex_dest=2, instruction reads rt=$2 (R-type).
  - Response: pds_o_stall=1 for one cycle, pds_o_ce=0 bubble, then the instruction issues.
  - Same setup with addi (rt not a read source) → no stall.
- Back-pressure and flush:
  - ex_ready=0 for 3 cycles → outputs frozen, pds_o_stall=1; the instruction issues after ready returns.
  - flush together with ready=0 → pds_o_ce=0 next cycle, pds_o_stall=0.
- Destination and jal:
  - jal → dest=31, reg_wr=1.
  - jr → reg_wr=0.
  - sw → reg_wr=0, rt read.
  - Stream of 8 back-to-back instructions with no hazards → 8 consecutive valid cycles.

Source files
------------

// File: rtl/pipelined_decode_stage.sv
// MIPS32 decode stage: field extraction, register file with write-back
// bypass, immediate extension, destination select, load-use interlock and a
// stallable/flushable ID/EX pipeline register.
//
// Handshake: pds_o_ce is the valid toward execute and pds_i_ex_ready its
// ready; an output transfers on a rising edge where both are 1, and while
// pds_o_ce=1 and pds_i_ex_ready=0 every output holds. Toward fetch,
// pds_i_ce is the valid and ~pds_o_stall the ready; an instruction is
// consumed on an edge where pds_i_ce=1 and pds_o_stall=0, otherwise fetch
// keeps pds_i_instr/pds_i_ce unchanged.
module pipelined_decode_stage #(
  parameter int AWIDTH    = 5,
  parameter int DWIDTH    = 32,
  parameter int IWIDTH    = 32,
  parameter int IMM_WIDTH = 16
) (
  input  logic              pds_clk,
  input  logic              pds_rst,
  input  logic              pds_i_ce,
  input  logic [IWIDTH-1:0] pds_i_instr,
  output logic              pds_o_stall,
  input  logic              pds_i_flush,
  input  logic              pds_i_ex_ready,
  input  logic              pds_i_ex_load,
  input  logic [AWIDTH-1:0] pds_i_ex_dest,
  input  logic              pds_i_wb_en,
  input  logic [AWIDTH-1:0] pds_i_wb_addr,
  input  logic [DWIDTH-1:0] pds_i_wb_data,
  output logic              pds_o_ce,
  output logic [5:0]        pds_o_opcode,
  output logic [5:0]        pds_o_funct,
  output logic [AWIDTH-1:0] pds_o_addr_rs,
  output logic [AWIDTH-1:0] pds_o_addr_rt,
  output logic [AWIDTH-1:0] pds_o_dest,
  output logic [DWIDTH-1:0] pds_o_data_rs,
  output logic [DWIDTH-1:0] pds_o_data_rt,
  output logic [DWIDTH-1:0] pds_o_imm,
  output logic              pds_o_reg_wr
);

  localparam int NREGS = 2 ** AWIDTH;

  logic [DWIDTH-1:0]    regs [NREGS];

  logic [5:0]           opcode;
  logic [5:0]           funct;
  logic [AWIDTH-1:0]    rs;
  logic [AWIDTH-1:0]    rt;
  logic [AWIDTH-1:0]    rd;
  logic [IMM_WIDTH-1:0] imm_field;

  logic [DWIDTH-1:0]    data_rs;
  logic [DWIDTH-1:0]    data_rt;
  logic [DWIDTH-1:0]    imm_ext;
  logic [AWIDTH-1:0]    dest;
  logic                 reg_wr;
  logic                 rt_is_src;
  logic                 load_use;
  logic                 hold;
  logic                 wb_write;

  // Field extraction from the presented instruction word.
  always_comb begin
    opcode    = pds_i_instr[31:26];
    rs        = pds_i_instr[25:21];
    rt        = pds_i_instr[20:16];
    rd        = pds_i_instr[15:11];
    funct     = pds_i_instr[5:0];
    imm_field = pds_i_instr[IMM_WIDTH-1:0];
  end

  assign wb_write = pds_i_wb_en && (pds_i_wb_addr != '0);

  // Register file: cleared by reset, written at the edge; $0 never written.
  always_ff @(posedge pds_clk or negedge pds_rst) begin
    if (!pds_rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wb_write) begin
      regs[pds_i_wb_addr] <= pds_i_wb_data;
    end
  end

  // Operand read with same-cycle write-back bypass; $0 always reads zero.
  always_comb begin
    data_rs = regs[rs];
    data_rt = regs[rt];
    if (rs == '0)                             data_rs = '0;
    else if (wb_write && pds_i_wb_addr == rs) data_rs = pds_i_wb_data;
    if (rt == '0)                             data_rt = '0;
    else if (wb_write && pds_i_wb_addr == rt) data_rt = pds_i_wb_data;
  end

  // Immediate extension: andi/ori/xori zero-extend, everything else signs.
  always_comb begin
    if (opcode == 6'h0C || opcode == 6'h0D || opcode == 6'h0E)
      imm_ext = '0;
    else
      imm_ext = {DWIDTH{imm_field[IMM_WIDTH-1]}};
    imm_ext[IMM_WIDTH-1:0] = imm_field;
  end

  // Destination register, write-enable and rt-usage classification.
  always_comb begin
    if (opcode == 6'h00)      dest = rd;
    else if (opcode == 6'h03) dest = {AWIDTH{1'b1}};
    else                      dest = rt;

    reg_wr = ((opcode == 6'h00) && (funct != 6'h08))
          || (opcode[5:3] == 3'b001)
          || (opcode == 6'h23)
          || (opcode == 6'h03);

    rt_is_src = (opcode == 6'h00) || (opcode == 6'h04)
             || (opcode == 6'h05) || (opcode == 6'h2B);
  end

  // Interlock and stall: gated by reset so stall reads 0 while reset is held.
  always_comb begin
    load_use = pds_i_ce && pds_i_ex_load && (pds_i_ex_dest != '0)
            && ((pds_i_ex_dest == rs) || (rt_is_src && (pds_i_ex_dest == rt)));
    hold        = pds_o_ce && !pds_i_ex_ready;
    pds_o_stall = pds_rst && !pds_i_flush && (hold || load_use);
  end

  // ID/EX register: flush beats hold, hold beats the load-use bubble.
  always_ff @(posedge pds_clk or negedge pds_rst) begin
    if (!pds_rst) begin
      pds_o_ce      <= 1'b0;
      pds_o_opcode  <= '0;
      pds_o_funct   <= '0;
      pds_o_addr_rs <= '0;
      pds_o_addr_rt <= '0;
      pds_o_dest    <= '0;
      pds_o_data_rs <= '0;
      pds_o_data_rt <= '0;
      pds_o_imm     <= '0;
      pds_o_reg_wr  <= 1'b0;
    end else if (pds_i_flush) begin
      pds_o_ce <= 1'b0;
    end else if (!hold) begin
      if (load_use) begin
        pds_o_ce <= 1'b0;
      end else begin
        pds_o_ce      <= pds_i_ce;
        pds_o_opcode  <= opcode;
        pds_o_funct   <= funct;
        pds_o_addr_rs <= rs;
        pds_o_addr_rt <= rt;
        pds_o_dest    <= dest;
        pds_o_data_rs <= data_rs;
        pds_o_data_rt <= data_rt;
        pds_o_imm     <= imm_ext;
        pds_o_reg_wr  <= reg_wr;
      end
    end
  end

endmodule

// File: tb/tb_pipelined_decode_stage.sv
// Directed bench for pipelined_decode_stage: reset, decode classes,
// bypass, load-use interlock, back-pressure, flush and a hazard-free stream.
module tb_pipelined_decode_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_ce;
  logic [31:0] i_instr;
  logic        o_stall;
  logic        i_flush;
  logic        i_ex_ready;
  logic        i_ex_load;
  logic [4:0]  i_ex_dest;
  logic        i_wb_en;
  logic [4:0]  i_wb_addr;
  logic [31:0] i_wb_data;
  logic        o_ce;
  logic [5:0]  o_opcode;
  logic [5:0]  o_funct;
  logic [4:0]  o_addr_rs;
  logic [4:0]  o_addr_rt;
  logic [4:0]  o_dest;
  logic [31:0] o_data_rs;
  logic [31:0] o_data_rt;
  logic [31:0] o_imm;
  logic        o_reg_wr;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] exp_q[$];

  pipelined_decode_stage dut (
    .pds_clk        (clk),
    .pds_rst        (rst),
    .pds_i_ce       (i_ce),
    .pds_i_instr    (i_instr),
    .pds_o_stall    (o_stall),
    .pds_i_flush    (i_flush),
    .pds_i_ex_ready (i_ex_ready),
    .pds_i_ex_load  (i_ex_load),
    .pds_i_ex_dest  (i_ex_dest),
    .pds_i_wb_en    (i_wb_en),
    .pds_i_wb_addr  (i_wb_addr),
    .pds_i_wb_data  (i_wb_data),
    .pds_o_ce       (o_ce),
    .pds_o_opcode   (o_opcode),
    .pds_o_funct    (o_funct),
    .pds_o_addr_rs  (o_addr_rs),
    .pds_o_addr_rt  (o_addr_rt),
    .pds_o_dest     (o_dest),
    .pds_o_data_rs  (o_data_rs),
    .pds_o_data_rt  (o_data_rt),
    .pds_o_imm      (o_imm),
    .pds_o_reg_wr   (o_reg_wr)
  );

  // Clock and reset
  always #5 clk = ~clk;

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    i_ce       = 1'b0;
    i_instr    = 32'h0;
    i_flush    = 1'b0;
    i_ex_ready = 1'b1;
    i_ex_load  = 1'b0;
    i_ex_dest  = 5'd0;
    i_wb_en    = 1'b0;
    i_wb_addr  = 5'd0;
    i_wb_data  = 32'h0;
  endtask

  task automatic wb_write(input logic [4:0] addr, input logic [31:0] data);
    i_wb_en   = 1'b1;
    i_wb_addr = addr;
    i_wb_data = data;
    step();
    i_wb_en   = 1'b0;
  endtask

  task automatic present(input logic [31:0] instr);
    i_ce    = 1'b1;
    i_instr = instr;
  endtask

  // Scoreboard comparison
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  logic [31:0] stream_instr [8];
  logic [31:0] stream_dest  [8];
  int          valid_run;

  initial begin
    stream_instr = '{32'h00221820, 32'h2005FFFF, 32'h3406FFFF, 32'h3C071234,
                     32'h8C290000, 32'h30238000, 32'h0C000010, 32'h00804020};
    stream_dest  = '{32'd3, 32'd5, 32'd6, 32'd7, 32'd9, 32'd3, 32'd31, 32'd8};

    // Reset held while inputs are active (including a would-be hazard)
    rst = 1'b0;
    idle();
    present(32'h00221820);
    i_ex_load = 1'b1;
    i_ex_dest = 5'd1;
    i_wb_en   = 1'b1;
    i_wb_addr = 5'd1;
    i_wb_data = 32'd99;
    step();
    step();
    chk("rst_ce",      32'(o_ce), 0);
    chk("rst_data_rs", o_data_rs, 0);
    chk("rst_dest",    32'(o_dest), 0);
    chk("rst_imm",     o_imm, 0);
    chk("rst_reg_wr",  32'(o_reg_wr), 0);
    chk("rst_stall",   32'(o_stall), 0);
    idle();
    rst = 1'b1;

    // Register file cleared: $1 was written only during reset
    present(32'h00221820);
    step();
    chk("clr_ce",      32'(o_ce), 1);
    chk("clr_data_rs", o_data_rs, 0);
    chk("clr_data_rt", o_data_rt, 0);
    i_ce = 1'b0;

    // Preload and first instruction: add $3,$1,$2
    wb_write(5'd1, 32'd5);
    wb_write(5'd2, 32'd7);
    chk("bubble_ce", 32'(o_ce), 0);
    present(32'h00221820);
    step();
    chk("add_ce",      32'(o_ce), 1);
    chk("add_data_rs", o_data_rs, 5);
    chk("add_data_rt", o_data_rt, 7);
    chk("add_dest",    32'(o_dest), 3);
    chk("add_reg_wr",  32'(o_reg_wr), 1);
    chk("add_opcode",  32'(o_opcode), 0);
    chk("add_funct",   32'(o_funct), 32'h20);
    chk("add_addr_rs", 32'(o_addr_rs), 1);
    chk("add_addr_rt", 32'(o_addr_rt), 2);

    // Immediate extension
    present(32'h2005FFFF);          // addi $5,$0,-1
    step();
    chk("addi_imm",    o_imm, 32'hFFFFFFFF);
    chk("addi_dest",   32'(o_dest), 5);
    chk("addi_reg_wr", 32'(o_reg_wr), 1);
    present(32'h3406FFFF);          // ori $6,$0,0xFFFF
    step();
    chk("ori_imm",     o_imm, 32'h0000FFFF);
    present(32'h3C071234);          // lui $7,0x1234
    step();
    chk("lui_reg_wr",  32'(o_reg_wr), 1);
    chk("lui_dest",    32'(o_dest), 7);
    chk("lui_imm",     o_imm, 32'h00001234);
    present(32'h30238000);          // andi $3,$1,0x8000
    step();
    chk("andi_imm",    o_imm, 32'h00008000);
    present(32'h24238000);          // addiu $3,$1,-32768
    step();
    chk("addiu_imm",   o_imm, 32'hFFFF8000);

    // Same-cycle write-back bypass, then regfile read of the same value
    i_wb_en   = 1'b1;
    i_wb_addr = 5'd4;
    i_wb_data = 32'hA5A5A5A5;
    present(32'h00804020);          // add $8,$4,$0
    step();
    i_wb_en = 1'b0;
    chk("byp_data_rs", o_data_rs, 32'hA5A5A5A5);
    chk("byp_data_rt", o_data_rt, 0);
    chk("byp_dest",    32'(o_dest), 8);
    step();
    chk("rf_data_rs",  o_data_rs, 32'hA5A5A5A5);

    // Register 0: write attempt must not bypass nor stick
    i_wb_en   = 1'b1;
    i_wb_addr = 5'd0;
    i_wb_data = 32'hDEADBEEF;
    present(32'h00004020);          // add $8,$0,$0
    step();
    i_wb_en = 1'b0;
    chk("r0_byp",      o_data_rs, 0);
    step();
    chk("r0_rf",       o_data_rs, 0);

    // Load-use on rt of an R-type: one bubble, then issue
    i_ex_load = 1'b1;
    i_ex_dest = 5'd2;
    present(32'h00221820);
    #1;
    chk("lu_stall",    32'(o_stall), 1);
    step();
    chk("lu_bubble",   32'(o_ce), 0);
    i_ex_load = 1'b0;               // load moved on; EX now holds the bubble
    #1;
    chk("lu_released", 32'(o_stall), 0);
    step();
    chk("lu_issue_ce", 32'(o_ce), 1);
    chk("lu_issue_rt", o_data_rt, 7);
    chk("lu_issue_dst",32'(o_dest), 3);

    // addi: rt is a destination, not a source -> no stall
    i_ex_load = 1'b1;
    i_ex_dest = 5'd2;
    present(32'h20220005);          // addi $2,$1,5
    #1;
    chk("addi_nostall", 32'(o_stall), 0);
    i_ex_dest = 5'd1;               // same instruction, hazard on rs
    #1;
    chk("addi_rs_stall", 32'(o_stall), 1);
    i_ex_dest = 5'd2;
    #1;
    step();
    chk("addi_lu_ce",  32'(o_ce), 1);
    chk("addi_lu_rs",  o_data_rs, 5);
    chk("addi_lu_imm", o_imm, 5);
    i_ex_load = 1'b0;

    // Back-pressure: outputs frozen while EX not ready
    present(32'h3406FFFF);
    step();
    present(32'h3C071234);
    i_ex_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("bp_stall", 32'(o_stall), 1);
      step();
      chk("bp_ce",    32'(o_ce), 1);
      chk("bp_imm",   o_imm, 32'h0000FFFF);
      chk("bp_dest",  32'(o_dest), 6);
    end
    i_ex_ready = 1'b1;
    #1;
    chk("bp_release", 32'(o_stall), 0);
    step();
    chk("bp_issue_imm",  o_imm, 32'h00001234);
    chk("bp_issue_dest", 32'(o_dest), 7);

    // Flush together with hold: flush wins
    present(32'h00221820);
    i_ex_ready = 1'b0;
    i_flush    = 1'b1;
    #1;
    chk("fl_stall", 32'(o_stall), 0);
    step();
    chk("fl_ce",    32'(o_ce), 0);
    i_flush    = 1'b0;
    i_ex_ready = 1'b1;

    // jal / jr / sw / lw / beq classification
    present(32'h0C000010);          // jal
    step();
    chk("jal_dest",   32'(o_dest), 31);
    chk("jal_reg_wr", 32'(o_reg_wr), 1);
    present(32'h03E00008);          // jr $31
    step();
    chk("jr_reg_wr",  32'(o_reg_wr), 0);
    chk("jr_ce",      32'(o_ce), 1);
    present(32'hAC220004);          // sw $2,4($1)
    i_ex_load = 1'b1;
    i_ex_dest = 5'd2;
    #1;
    chk("sw_rt_stall", 32'(o_stall), 1);
    i_ex_load = 1'b0;
    #1;
    step();
    chk("sw_reg_wr",  32'(o_reg_wr), 0);
    chk("sw_data_rt", o_data_rt, 7);
    chk("sw_imm",     o_imm, 4);
    present(32'h8C290000);          // lw $9,0($1)
    step();
    chk("lw_reg_wr",  32'(o_reg_wr), 1);
    chk("lw_dest",    32'(o_dest), 9);
    present(32'h1022FFFF);          // beq $1,$2,-1
    step();
    chk("beq_reg_wr", 32'(o_reg_wr), 0);
    chk("beq_imm",    o_imm, 32'hFFFFFFFF);
    i_ce = 1'b0;
    step();

    // Hazard-free stream of 8: expect 8 consecutive valid cycles
    valid_run = 0;
    for (int k = 0; k < 8; k++) begin
      present(stream_instr[k]);
      exp_q.push_back(stream_dest[k]);
      step();
      if (o_ce) valid_run++;
      chk("stream_ce", 32'(o_ce), 1);
      if (exp_q.size() > 0) chk("stream_dest", 32'(o_dest), exp_q.pop_front());
    end
    i_ce = 1'b0;
    step();
    chk("stream_run",  32'(valid_run), 8);
    chk("stream_tail", 32'(o_ce), 0);

    // Reset asserted mid-stall clears the pipeline register and regfile
    present(32'h00221820);
    step();
    i_ex_ready = 1'b0;
    #2;
    chk("mid_pre_stall", 32'(o_stall), 1);
    rst = 1'b0;
    #1;
    chk("mid_rst_ce",    32'(o_ce), 0);
    chk("mid_rst_rs",    o_data_rs, 0);
    chk("mid_rst_stall", 32'(o_stall), 0);
    step();
    idle();
    rst = 1'b1;
    present(32'h00221820);
    step();
    chk("post_rst_ce", 32'(o_ce), 1);
    chk("post_rst_rs", o_data_rs, 0);
    chk("post_rst_rt", o_data_rt, 0);
    i_ce = 1'b0;
    step();

    // Final report
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
